jk_reg_bank: RTL and testbench

Parametrised WIDTH-bit register bank built from JK flip-flop cells, the next generation of the lab single-bit JK flip-flop. Four run-time modes share one register: independent per-bit JK, synchronous up/down binary counter (JK toggle chain), serial shift register, and Johnson counter. Synchronous parallel load replaces the old per-bit preset; a registered terminal-count flag supports cascading. It sits in the digital-logic experiment set as the general-purpose sequential primitive.

---
 rtl/jk_bank_pkg.sv | 14 +
 rtl/jk_cell.sv | 21 ++
 rtl/jk_reg_bank.sv | 104 ++++++++++
 tb/tb_jk_reg_bank.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/jk_bank_pkg.sv
// Shared definitions for the JK register bank: the run-time mode encoding.
package jk_bank_pkg;

  typedef enum logic [1:0] {
    MODE_JK      = 2'b00,
    MODE_COUNT   = 2'b01,
    MODE_SHIFT   = 2'b10,
    MODE_JOHNSON = 2'b11
  } mode_e;

  // Width of the mode field on the bank's pins.
  localparam int unsigned MODE_W = 2;

endpackage

// File: rtl/jk_cell.sv
// Combinational next-state for a single JK flip-flop cell.
module jk_cell (
  input  logic q,
  input  logic j,
  input  logic k,
  output logic q_next
);

  // Classic JK table: hold, clear, set, toggle.
  always_comb begin
    q_next = q;
    case ({j, k})
      2'b00:   q_next = q;
      2'b01:   q_next = 1'b0;
      2'b10:   q_next = 1'b1;
      2'b11:   q_next = ~q;
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit register bank of JK cells with JK, up/down counter, shift and
// Johnson modes, synchronous parallel load and a registered terminal-count
// pulse. All state changes on the falling edge of clk.
module jk_reg_bank
  import jk_bank_pkg::*;
#(
  parameter int unsigned    WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             up,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             tc
);

  mode_e            mode_s;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic [WIDTH-1:0] cell_q;
  logic [WIDTH-1:0] q_next;
  logic             wrap;
  logic             tc_next;

  assign mode_s = mode_e'(mode);
  assign q_n    = ~q;

  // Counter toggle chain: bit i toggles when every lower bit is 1 (up)
  // or 0 (down); bit 0 always toggles.
  always_comb begin
    toggle    = '0;
    toggle[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      toggle[i] = toggle[i-1] & (up ? q[i-1] : ~q[i-1]);
    end
  end

  // Cells take J/K from the pins in JK mode and the toggle chain in COUNT
  // mode; in the other modes their output is not selected.
  always_comb begin
    cell_j = j;
    cell_k = k;
    if (mode_s == MODE_COUNT) begin
      cell_j = toggle;
      cell_k = toggle;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .q      (q[g]),
      .j      (cell_j[g]),
      .k      (cell_k[g]),
      .q_next (cell_q[g])
    );
  end

  // Wrap happens when the whole chain toggles: all-ones going up or
  // all-zeros going down.
  assign wrap = up ? (&q) : ~(|q);

  // Shared next-state mux: load beats hold, hold beats the mode function.
  always_comb begin
    q_next  = q;
    tc_next = 1'b0;
    if (load) begin
      q_next = d;
    end else if (!en) begin
      q_next = q;
    end else begin
      case (mode_s)
        MODE_JK:      q_next = cell_q;
        MODE_COUNT: begin
          q_next  = cell_q;
          tc_next = wrap;
        end
        MODE_SHIFT:   q_next = {q[WIDTH-2:0], ser_in};
        MODE_JOHNSON: q_next = {q[WIDTH-2:0], ~q[WIDTH-1]};
        default:      q_next = q;
      endcase
    end
  end

  // State register on the falling edge with asynchronous reset.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      q  <= RST_VAL;
      tc <= 1'b0;
    end else begin
      q  <= q_next;
      tc <= tc_next;
    end
  end

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank (WIDTH=4, RST_VAL=0).
module tb_jk_reg_bank;

  localparam int unsigned W = 4;

  // Clock / reset
  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic         up;
  logic         ser_in;
  logic [W-1:0] q;
  logic [W-1:0] q_n;
  logic         tc;

  logic [W-1:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(W), .RST_VAL(4'b0000)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .load   (load),
    .d      (d),
    .j      (j),
    .k      (k),
    .up     (up),
    .ser_in (ser_in),
    .q      (q),
    .q_n    (q_n),
    .tc     (tc)
  );

  // Scoreboard check: all comparisons go through here.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance past one falling edge and settle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Driver: one falling edge with the given controls.
  task automatic drive(input logic l, input logic [W-1:0] dv, input logic e,
                       input logic [1:0] m, input logic u, input logic s);
    load = l; d = dv; en = e; mode = m; up = u; ser_in = s;
    step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; d = '0;
    j = '0; k = '0; up = 1'b1; ser_in = 1'b0;
    #2;
    check("rst_q", q, 4'b0000);
    check("rst_qn", q_n, 4'b1111);
    check("rst_tc", tc, 1'b0);
    step();
    rst = 1'b0;

    // Count up a little, then async reset between edges.
    drive(0, '0, 1, 2'b01, 1, 0);
    check("cnt_1", q, 4'b0001);
    drive(0, '0, 1, 2'b01, 1, 0);
    check("cnt_2", q, 4'b0010);
    #2 rst = 1'b1;
    #1;
    check("arst_q", q, 4'b0000);
    check("arst_qn", q_n, 4'b1111);
    check("arst_tc", tc, 1'b0);
    #1 rst = 1'b0;
    drive(0, '0, 1, 2'b01, 1, 0);
    check("cnt_resume", q, 4'b0001);

    // JK mode: hold, clear, toggle, set.
    drive(1, 4'b0101, 1, 2'b00, 1, 0);
    check("jk_load", q, 4'b0101);
    j = 4'b0011; k = 4'b0110;
    drive(0, '0, 1, 2'b00, 1, 0);
    check("jk_next", q, 4'b0011);
    check("jk_qn", q_n, 4'b1100);
    j = '0; k = '0;

    // COUNT up through wrap.
    drive(1, 4'b1110, 1, 2'b01, 1, 0);
    check("cu_load", q, 4'b1110);
    drive(0, '0, 1, 2'b01, 1, 0);
    check("cu_q1", q, 4'b1111);
    check("cu_tc1", tc, 1'b0);
    drive(0, '0, 1, 2'b01, 1, 0);
    check("cu_q2", q, 4'b0000);
    check("cu_tc2", tc, 1'b1);
    drive(0, '0, 1, 2'b01, 1, 0);
    check("cu_q3", q, 4'b0001);
    check("cu_tc3", tc, 1'b0);

    // COUNT down through wrap.
    drive(1, 4'b0001, 1, 2'b01, 0, 0);
    check("cd_load_tc", tc, 1'b0);
    drive(0, '0, 1, 2'b01, 0, 0);
    check("cd_q1", q, 4'b0000);
    check("cd_tc1", tc, 1'b0);
    drive(0, '0, 1, 2'b01, 0, 0);
    check("cd_q2", q, 4'b1111);
    check("cd_tc2", tc, 1'b1);

    // Hold with en=0: q frozen, tc cleared.
    drive(0, '0, 0, 2'b01, 0, 0);
    check("hold_q1", q, 4'b1111);
    check("hold_tc1", tc, 1'b0);
    drive(0, '0, 0, 2'b01, 0, 0);
    check("hold_q2", q, 4'b1111);
    check("hold_tc2", tc, 1'b0);

    // SHIFT with ser_in 1,0,1,1.
    drive(1, 4'b0000, 1, 2'b10, 1, 0);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0101); exp_q.push_back(4'b1011);
    drive(0, '0, 1, 2'b10, 1, 1); check("sh_0", q, exp_q.pop_front());
    drive(0, '0, 1, 2'b10, 1, 0); check("sh_1", q, exp_q.pop_front());
    drive(0, '0, 1, 2'b10, 1, 1); check("sh_2", q, exp_q.pop_front());
    drive(0, '0, 1, 2'b10, 1, 1); check("sh_3", q, exp_q.pop_front());

    // JOHNSON full period from 0000.
    drive(1, 4'b0000, 1, 2'b11, 1, 0);
    exp_q = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
              4'b1110, 4'b1100, 4'b1000, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      drive(0, '0, 1, 2'b11, 1, 0);
      check($sformatf("jn_%0d", i), q, exp_q.pop_front());
    end

    // Load wins over en=0.
    drive(1, 4'b0101, 0, 2'b11, 1, 0);
    check("load_over_en", q, 4'b0101);

    // COUNT to 0110, then switch to SHIFT with ser_in=1.
    drive(0, '0, 1, 2'b01, 1, 0);
    check("sw_cnt", q, 4'b0110);
    drive(0, '0, 1, 2'b10, 1, 1);
    check("sw_shift", q, 4'b1101);
    check("sw_tc", tc, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
